cdb_arbiter: RTL



---
 rtl/rv32i_types.sv | 17 +
 rtl/cdb_rr_pick.sv | 50 +++++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the common data bus: the requester payload record and
// the default requester count and field widths.
package rv32i_types;

  localparam int N_CDB_REQ  = 4;
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_ID_W   = 4;
  localparam int CDB_DATA_W = 32;

  // One writeback result as it travels from a functional unit to the CDB.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_ID_W-1:0]   inst_id;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_req_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational one-hot picker for the CDB holding slots.
// Default: round-robin search starting at rr_ptr, wrapping N_REQ-1 -> 0.
// Macro CDB_FIXED_PRIO_EN: fixed priority, index 0 highest, rr_ptr ignored.
module cdb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] hold_v,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant
);

`ifdef CDB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Scan from the top down so the lowest valid index is the last one written.
  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hold_v[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  int               idx_sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk N_REQ positions starting at rr_ptr; the first valid slot wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_sum = 0;
    idx     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx_sum = int'(rr_ptr) + off;
      if (idx_sum >= N_REQ) idx_sum = idx_sum - N_REQ;
      idx = idx_sum[PTR_W-1:0];
      if (!found && hold_v[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one 1-entry holding slot per writeback requester,
// one grant per cycle, registered CDB broadcast outputs, flush discards all.
// Build option: CDB_FIXED_PRIO_EN selects fixed priority (index 0 highest)
// instead of the default round-robin; rr_ptr is then constant zero.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_REQ = N_CDB_REQ
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [N_REQ-1:0]                     req_valid,
  output logic [N_REQ-1:0]                     req_ready,
  input  logic [N_REQ-1:0][CDB_TAG_W-1:0]      req_tag,
  input  logic [N_REQ-1:0][CDB_ID_W-1:0]       req_inst_id,
  input  logic [N_REQ-1:0][CDB_DATA_W-1:0]     req_wdata,
  output logic                                 cdb_wr,
  output logic [CDB_TAG_W-1:0]                 cdb_tag,
  output logic [CDB_ID_W-1:0]                  cdb_inst_id,
  output logic [CDB_DATA_W-1:0]                cdb_wdata,
  output logic [N_REQ-1:0]                     cdb_src
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  cdb_req_t         req_pkt [N_REQ];
  cdb_req_t         slot    [N_REQ];
  cdb_req_t         win_pkt;
  logic [N_REQ-1:0] hold_v;
  logic [N_REQ-1:0] grant_raw;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] accept;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_next;
  logic             any_grant;

  genvar gi;

  for (gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_pkt[gi] = {req_tag[gi], req_inst_id[gi], req_wdata[gi]};
  end

  cdb_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .hold_v (hold_v),
    .rr_ptr (rr_ptr),
    .grant  (grant_raw)
  );

  // Nothing is granted or accepted in a flush cycle.
  assign grant     = flush ? '0 : grant_raw;
  assign any_grant = |grant;
  assign req_ready = {N_REQ{~flush}} & (~hold_v | grant);
  assign accept    = req_valid & req_ready;

  // Slot occupancy: a grant empties the slot unless it is refilled the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) hold_v <= '0;
    else              hold_v <= (hold_v & ~grant) | accept;
  end

  // Slot payload keeps its own copy so the requester may move on after the handshake.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) slot[i] <= req_pkt[i];
    end
  end

  // Select the granted payload and the pointer position just past the winner.
  always_comb begin
    win_pkt     = '0;
    rr_ptr_next = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_pkt     = slot[i];
        rr_ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  logic unused_rr_ptr_next;
  assign unused_rr_ptr_next = ^rr_ptr_next;
  assign rr_ptr             = '0;
`else
  // Round-robin pointer advances only when something was granted.
  always_ff @(posedge clk) begin
    if (rst || flush) rr_ptr <= '0;
    else              rr_ptr <= rr_ptr_next;
  end
`endif

  // CDB broadcast registers; idle cycles drive all-zero with cdb_wr low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_wr      <= 1'b0;
      cdb_tag     <= '0;
      cdb_inst_id <= '0;
      cdb_wdata   <= '0;
      cdb_src     <= '0;
    end else begin
      cdb_wr      <= any_grant;
      cdb_tag     <= win_pkt.tag;
      cdb_inst_id <= win_pkt.inst_id;
      cdb_wdata   <= win_pkt.wdata;
      cdb_src     <= grant;
    end
  end

  // Tag 0 means "no tag" downstream, so an accepted result must never carry it.
  for (gi = 0; gi < N_REQ; gi++) begin : g_tag_chk
    a_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
      accept[gi] |-> (req_tag[gi] != '0));
  end

endmodule
